// File: rtl/mips8_ctrl_fsm_pkg.sv
// Shared types and encodings for the 8-bit MIPS multicycle controller.
package mips8_pkg;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4,
    DECODE, MEMADR, LBRD, LBWR,
    SBWR, RTYPEEX, RTYPEWR, BEQEX,
    JEX, ADDIEX, ADDIWR, TRAP
  } state_e;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b101;

endpackage

// File: rtl/mips8_ctrl_fsm_if.sv
// Controller <-> datapath bundle: decoded fields in, control strobes out.
interface mips8_ctrl_fsm_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       pcen;
  logic [3:0] irwrite;
  logic       iord;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output alucontrol, alusrca, alusrcb,
    output pcsource, pcen, irwrite,
    output iord, memwrite, regwrite,
    output regdst, memtoreg, illegal
  );

  modport slave (
    output op, funct, zero,
    input  alucontrol, alusrca, alusrcb,
    input  pcsource, pcen, irwrite,
    input  iord, memwrite, regwrite,
    input  regdst, memtoreg, illegal
  );

endinterface

// File: rtl/mips8_ctrl_fsm_alu_dec.sv
// R-type funct decode to ALU operation plus a supported-funct flag.
module alu_dec
  import mips8_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] aluctl_o,
  output logic       ok_o
);

  always_comb begin
    aluctl_o = ALU_ADD;
    ok_o     = 1'b0;
    unique case (funct_i)
      FN_ADD: ok_o = 1'b1;
      FN_SUB: begin
        aluctl_o = ALU_SUB;
        ok_o     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips8_ctrl_fsm.sv
// Multicycle Moore controller for the 8-bit MIPS subset.
// Build option ILLEGAL_TRAP_EN: park in TRAP on unsupported op/funct.
module mips8_ctrl_fsm
  import mips8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mips8_ctrl_fsm_if.master   bus
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e BAD_NEXT = TRAP;
`else
  localparam state_e BAD_NEXT = FETCH1;
`endif

  state_e     state_q;
  state_e     state_d;
  logic [2:0] fn_alu;
  logic       fn_ok;

  alu_dec u_alu_dec (
    .funct_i  (bus.funct),
    .aluctl_o (fn_alu),
    .ok_o     (fn_ok)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        unique case (bus.op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = BAD_NEXT;
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_SB) ? SBWR : LBRD;
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = fn_ok ? RTYPEWR : BAD_NEXT;
      ADDIEX:  state_d = ADDIWR;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode the registered state; only beq's pcen looks at zero.
  always_comb begin
    bus.alucontrol = ALU_ADD;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsource   = 2'b00;
    bus.pcen       = 1'b0;
    bus.irwrite    = 4'b0000;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.illegal    = 1'b0;
    unique case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        bus.alusrcb = 2'b01;
        bus.pcen    = 1'b1;
        bus.irwrite = {state_q == FETCH4,
                       state_q == FETCH3,
                       state_q == FETCH2,
                       state_q == FETCH1};
      end
      DECODE: bus.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      LBRD: bus.iord = 1'b1;
      LBWR: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      SBWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      RTYPEEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = fn_alu;
      end
      RTYPEWR: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      BEQEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsource   = 2'b01;
        bus.pcen       = bus.zero;
      end
      JEX: begin
        bus.pcsource = 2'b10;
        bus.pcen     = 1'b1;
      end
      ADDIWR: bus.regwrite = 1'b1;
      default: ;
    endcase
`ifdef ILLEGAL_TRAP_EN
    bus.illegal = (state_q == TRAP);
`endif
  end

endmodule

// File: tb/tb_mips8_ctrl_fsm.sv
// Random instruction stream against a per-instruction control-sequence model.
module tb_mips8_ctrl_fsm;

  typedef enum int {
    K_LB, K_SB, K_RADD, K_RSUB, K_RBAD,
    K_BEQ, K_J, K_ADDI, K_BADOP
  } kind_e;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mips8_ctrl_fsm_if bus ();

  mips8_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [18:0] obs();
    return {bus.alucontrol, bus.alusrca, bus.alusrcb,
            bus.pcsource, bus.pcen, bus.irwrite,
            bus.iord, bus.memwrite, bus.regwrite,
            bus.regdst, bus.memtoreg, bus.illegal};
  endfunction

  function automatic logic [18:0] mkv(
    logic [2:0] alu, logic a, logic [1:0] b,
    logic [1:0] pcs, logic pcen, logic [3:0] irw,
    logic io, logic mw, logic rw, logic rd,
    logic mtr, logic ill);
    return {alu, a, b, pcs, pcen, irw,
            io, mw, rw, rd, mtr, ill};
  endfunction

  function automatic logic [18:0] fetch_v(int n);
    logic [3:0] one;
    one = 4'b0001 << n;
    return mkv(ADD, 0, 2'b01, 2'b00, 1, one,
               0, 0, 0, 0, 0, 0);
  endfunction

  function automatic int tail_len(kind_e k);
    case (k)
      K_LB:              return 3;
      K_SB:              return 2;
      K_RADD, K_RSUB:    return 2;
      K_ADDI:            return 2;
      K_RBAD, K_BEQ, K_J: return 1;
      default:           return 0;
    endcase
  endfunction

  // Cycle t after DECODE for instruction kind k.
  function automatic logic [18:0] tail_v(kind_e k, int t,
                                         logic z);
    logic [18:0] nop;
    nop = mkv(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    case (k)
      K_LB, K_SB: begin
        if (t == 0)
          return mkv(ADD, 1, 2'b10, 0, 0, 0,
                     0, 0, 0, 0, 0, 0);
        if (k == K_SB)
          return mkv(ADD, 0, 0, 0, 0, 0,
                     1, 1, 0, 0, 0, 0);
        if (t == 1)
          return mkv(ADD, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0);
        return mkv(ADD, 0, 0, 0, 0, 0,
                   0, 0, 1, 0, 1, 0);
      end
      K_RADD, K_RSUB, K_RBAD: begin
        if (t == 0)
          return mkv(k == K_RSUB ? SUB : ADD, 1, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        return mkv(ADD, 0, 0, 0, 0, 0,
                   0, 0, 1, 1, 0, 0);
      end
      K_BEQ:
        return mkv(SUB, 1, 0, 2'b01, z, 0,
                   0, 0, 0, 0, 0, 0);
      K_J:
        return mkv(ADD, 0, 0, 2'b10, 1, 0,
                   0, 0, 0, 0, 0, 0);
      K_ADDI: begin
        if (t == 0)
          return mkv(ADD, 1, 2'b10, 0, 0, 0,
                     0, 0, 0, 0, 0, 0);
        return mkv(ADD, 0, 0, 0, 0, 0,
                   0, 0, 1, 0, 0, 0);
      end
      default: return nop;
    endcase
  endfunction

  // Entered from anywhere; leaves the bench at posedge+1 of a FETCH1 cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async", obs(), fetch_v(0));
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", obs(), fetch_v(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(kind_e k, logic [5:0] op,
                     logic [5:0] fn, int zmode, int abort_at);
    int len;
    logic z;
    logic [18:0] e;
    len = 5 + tail_len(k);
    bus.op = op;
    bus.funct = fn;
    for (int p = 0; p < len; p++) begin
      z = (zmode < 0) ? 1'($urandom_range(0, 1))
                      : 1'(zmode);
      bus.zero = z;
      @(negedge clk);
      if (p < 4) e = fetch_v(p);
      else if (p == 4)
        e = mkv(ADD, 0, 2'b11, 0, 0, 0,
                0, 0, 0, 0, 0, 0);
      else e = tail_v(k, p - 5, z);
      chk($sformatf("%s_p%0d", k.name(), p), obs(), e);
      chk("mw_rw_excl",
          32'(bus.memwrite & bus.regwrite), 0);
      if (p == abort_at) begin
        do_reset();
        return;
      end
      @(posedge clk);
      #1;
    end
`ifdef ILLEGAL_TRAP_EN
    if (k == K_RBAD || k == K_BADOP) begin
      for (int i = 0; i < 3; i++) begin
        bus.zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("trap", obs(), mkv(ADD, 0, 0, 0, 0, 0,
                              0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
      end
      do_reset();
    end
`endif
  endtask

  function automatic logic [5:0] op_of(kind_e k);
    logic [5:0] o;
    case (k)
      K_LB:                   return 6'b100000;
      K_SB:                   return 6'b101000;
      K_RADD, K_RSUB, K_RBAD: return 6'b000000;
      K_BEQ:                  return 6'b000100;
      K_J:                    return 6'b000010;
      K_ADDI:                 return 6'b001000;
      default: begin
        do o = 6'($urandom_range(0, 63));
        while (o inside {6'b100000, 6'b101000, 6'b000000,
                         6'b000100, 6'b000010, 6'b001000});
        return o;
      end
    endcase
  endfunction

  function automatic logic [5:0] fn_of(kind_e k);
    logic [5:0] f;
    if (k == K_RADD) return 6'b100000;
    if (k == K_RSUB) return 6'b100010;
    do f = 6'($urandom_range(0, 63));
    while (k == K_RBAD && f inside {6'b100000, 6'b100010});
    return f;
  endfunction

  initial begin
    kind_e k;
    int ab;
    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", obs(), fetch_v(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(K_RSUB, 6'b000000, 6'b100010, -1, -1);
    run(K_BEQ, 6'b000100, 6'b010101, 1, -1);
    run(K_BEQ, 6'b000100, 6'b010101, 0, -1);
    run(K_LB, 6'b100000, 6'b000000, -1, -1);
    run(K_SB, 6'b101000, 6'b000000, -1, -1);
    run(K_BADOP, 6'b111111, 6'b000000, -1, -1);
    run(K_LB, 6'b100000, 6'b000000, -1, 6);
    run(K_J, 6'b000010, 6'b000000, -1, -1);
    run(K_ADDI, 6'b001000, 6'b000000, -1, -1);
    run(K_RADD, 6'b000000, 6'b100000, -1, -1);
    run(K_RBAD, 6'b000000, 6'b100100, -1, -1);

    for (int i = 0; i < 80; i++) begin
      k = kind_e'($urandom_range(0, 8));
      ab = -1;
      if ($urandom_range(0, 9) == 0)
        ab = $urandom_range(0, 4 + tail_len(k));
      run(k, op_of(k), fn_of(k), -1, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
